pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer states,
// the canonical NOP encoding and the register-address width.
package pipe_pkg;

   localparam int          REG_AW    = 5;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

   // Load-use hit: EX loads a real register (not x0) that ID is about to read.
   function automatic logic load_use_hit(
      input logic              is_load,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] rs1,
      input logic [REG_AW-1:0] rs2
   );
      return is_load && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] ONE = W'(1);

   // Clear wins over increment; increment stops once all bits are set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges MEM wait
// states, multi-cycle mul/div occupancy, taken-branch redirects and load-use
// hazards into per-stage stall/flush controls, with saturating perf counters
// and a sticky watchdog on long data-memory waits.
//
// Handshake: a data-memory access is "waiting" while dmem_req_mem=1 and
// dmem_ready=0 and completes in the cycle dmem_ready=1; a mul/div operation
// is started by the one-cycle md_start pulse and completes in the cycle the
// md_done pulse is seen. state_dbg exposes the sequencer state.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MEM_TO_MAX = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] rd_addr_ex,
   input  logic [REG_AW-1:0] rs1_addr_id,
   input  logic [REG_AW-1:0] rs2_addr_id,
   input  logic              br_taken_ex,
   input  logic              md_req_ex,
   input  logic              md_done,
   input  logic              dmem_req_mem,
   input  logic              dmem_ready,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              stall_mem,
   output logic              flush_id,
   output logic              flush_ex,
   output logic              bubble_mem,
   output logic              bubble_wb,
   output logic [31:0]       nop_instr,
   output logic              md_start,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              mem_timeout,
   output logic [1:0]        state_dbg
);

   localparam int                WAIT_W     = $clog2(MEM_TO_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TO_MAX);

   hz_state_e         state;
   hz_state_e         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              load_use;
   logic              eval_md;
   logic              eval_hz;

   assign nop_instr = NOP_INSTR;
   assign state_dbg = state;
   assign load_use  = load_use_hit(ex_is_load, rd_addr_ex, rs1_addr_id, rs2_addr_id);

   // Control decode: MEM wait > MD wait > branch > load-use. When a wait
   // releases, the hazards held behind it are evaluated in that same cycle.
   always_comb begin
      state_nxt  = state;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      stall_mem  = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      bubble_mem = 1'b0;
      bubble_wb  = 1'b0;
      md_start   = 1'b0;
      eval_md    = 1'b0;
      eval_hz    = 1'b0;

      if (rst_n) begin
         case (state)
            RUN: begin
               if (dmem_req_mem && !dmem_ready) begin
                  {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                  bubble_wb = 1'b1;
                  state_nxt = MEM_WAIT;
               end else begin
                  eval_md = 1'b1;
                  eval_hz = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!dmem_ready) begin
                  {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                  bubble_wb = 1'b1;
               end else begin
                  state_nxt = RUN;
                  eval_md   = 1'b1;
                  eval_hz   = 1'b1;
               end
            end
            MD_WAIT: begin
               // The mul/div still sits in EX, so md_req_ex is not a new request.
               if (!md_done) begin
                  {stall_if, stall_id, stall_ex} = 3'b111;
                  bubble_mem = 1'b1;
               end else begin
                  state_nxt = RUN;
                  eval_hz   = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase

         if (eval_md && md_req_ex) begin
            md_start   = 1'b1;
            {stall_if, stall_id, stall_ex} = 3'b111;
            bubble_mem = 1'b1;
            state_nxt  = MD_WAIT;
         end else if (eval_hz && br_taken_ex) begin
            // ID holds a wrong-path instruction, so any load-use there is moot.
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (eval_hz && load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
         end
      end
   end

   // Sequencer state and sticky watchdog flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         mem_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wait_cnt >= WAIT_LIMIT) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_if),
      .clear (1'b0),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_id | flush_ex),
      .clear (1'b0),
      .cnt   (flush_cnt)
   );

   // Counts unready cycles of the current MEM wait; cleared outside the wait.
   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state == MEM_WAIT) && !dmem_ready),
      .clear (state != MEM_WAIT),
      .cnt   (wait_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int TB_CNT_W = 8;
   localparam int TO_MAX   = 255;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   localparam logic [1:0] M_RUN = 2'd0;
   localparam logic [1:0] M_MD  = 2'd1;
   localparam logic [1:0] M_MEM = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic                ex_is_load = 0, br_taken_ex = 0, md_req_ex = 0, md_done = 0;
   logic                dmem_req_mem = 0, dmem_ready = 0;
   logic [4:0]          rd_addr_ex = 0, rs1_addr_id = 0, rs2_addr_id = 0;
   logic                stall_if, stall_id, stall_ex, stall_mem;
   logic                flush_id, flush_ex, bubble_mem, bubble_wb, md_start, mem_timeout;
   logic [31:0]         nop_instr;
   logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
   logic [1:0]          state_dbg;

   pipe_hazard_ctrl #(.CNT_W(TB_CNT_W), .MEM_TO_MAX(TO_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .ex_is_load(ex_is_load), .rd_addr_ex(rd_addr_ex),
      .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id), .br_taken_ex(br_taken_ex),
      .md_req_ex(md_req_ex), .md_done(md_done), .dmem_req_mem(dmem_req_mem),
      .dmem_ready(dmem_ready), .stall_if(stall_if), .stall_id(stall_id),
      .stall_ex(stall_ex), .stall_mem(stall_mem), .flush_id(flush_id),
      .flush_ex(flush_ex), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
      .nop_instr(nop_instr), .md_start(md_start), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
   );

   logic [8:0] ctrl;
   assign ctrl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                  bubble_mem, bubble_wb, md_start};

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [8:0] ctrl;   // same bit order as the ctrl vector above
      logic [1:0] nxt;
   } exp_t;

   function automatic exp_t model_out(
      input logic [1:0] mode, input logic rst, input logic is_load,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic br, input logic mreq, input logic mdone,
      input logic dreq, input logic drdy
   );
      exp_t e;
      logic mem_blocked;
      e = '0;
      e.nxt = mode;
      if (!rst) return e;
      mem_blocked = (mode == M_MEM) ? !drdy : ((mode == M_RUN) && dreq && !drdy);
      if (mem_blocked) begin
         e.ctrl = 9'b1111_0001_0;
         e.nxt  = M_MEM;
      end else if ((mode == M_MD) && !mdone) begin
         e.ctrl = 9'b1110_0010_0;
      end else begin
         e.nxt = M_RUN;
         if ((mode != M_MD) && mreq) begin
            e.ctrl = 9'b1110_0010_1;
            e.nxt  = M_MD;
         end else if (br) begin
            e.ctrl = 9'b0000_1100_0;
         end else if (is_load && rd != 0 && (rd == rs1 || rd == rs2)) begin
            e.ctrl = 9'b1100_0100_0;
         end
      end
      return e;
   endfunction

   logic [1:0] m_mode;
   int         m_waits, m_scnt, m_fcnt;
   logic       m_tmo;
   exp_t       m_e;

   always_comb m_e = model_out(m_mode, rst_n, ex_is_load, rd_addr_ex, rs1_addr_id,
                               rs2_addr_id, br_taken_ex, md_req_ex, md_done,
                               dmem_req_mem, dmem_ready);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  <= M_RUN;
         m_waits <= 0;
         m_scnt  <= 0;
         m_fcnt  <= 0;
         m_tmo   <= 1'b0;
      end else begin
         if (m_e.ctrl[8] && m_scnt < CMAX) m_scnt <= m_scnt + 1;
         if ((m_e.ctrl[4] || m_e.ctrl[3]) && m_fcnt < CMAX) m_fcnt <= m_fcnt + 1;
         if (m_waits >= TO_MAX) m_tmo <= 1'b1;
         if (m_mode == M_MEM && !dmem_ready) m_waits <= m_waits + 1;
         else if (m_mode != M_MEM)           m_waits <= 0;
         m_mode <= m_e.nxt;
      end
   end

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ctrl", 64'(ctrl), 64'(m_e.ctrl));
         check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
         check("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
         check("mem_timeout", 64'(mem_timeout), 64'(m_tmo));
         check("nop_instr", 64'(nop_instr), 64'h13);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic br, input logic mreq,
                        input logic mdone, input logic dreq, input logic drdy);
      @(posedge clk);
      #2;
      ex_is_load = ld; rd_addr_ex = rd; rs1_addr_id = r1; rs2_addr_id = r2;
      br_taken_ex = br; md_req_ex = mreq; md_done = mdone;
      dmem_req_mem = dreq; dmem_ready = drdy;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- directed + random stimulus ----------------
   int md_starts, stall_cycles;

   initial begin
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_ctrl", 64'(ctrl), 64'h0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
      check("rst_timeout", 64'(mem_timeout), 64'h0);
      #2;
      rst_n = 1'b1;

      // Load-use on rs2 = x5: one-cycle stall with EX bubble.
      drive(1, 5, 1, 5, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("lu_ctrl", 64'(ctrl), 64'(9'b1100_0100_0));
      idle();
      @(negedge clk);
      check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      check("lu_released", 64'(stall_if), 64'h0);

      // Load to x0 never stalls.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("x0_ctrl", 64'(ctrl), 64'h0);

      // Branch overrides a simultaneous load-use.
      drive(1, 7, 7, 3, 1, 0, 0, 0, 1);
      @(negedge clk);
      check("br_ctrl", 64'(ctrl), 64'(9'b0000_1100_0));
      idle();
      @(negedge clk);
      check("br_flush_cnt", 64'(flush_cnt), 64'd2);

      // Mul/div with md_done 34 cycles after the request.
      md_starts = 0;
      stall_cycles = 0;
      for (int c = 0; c <= 34; c++) begin
         drive(0, 0, 0, 0, 0, 1, (c == 34), 0, 1);
         @(negedge clk);
         md_starts += int'(md_start);
         stall_cycles += int'(stall_if);
         if (c == 34) check("md_release", 64'({stall_if, bubble_mem}), 64'h0);
      end
      idle();
      @(negedge clk);
      check("md_start_pulses", 64'(md_starts), 64'd1);
      check("md_stall_cycles", 64'(stall_cycles), 64'd34);
      check("md_stall_cnt", 64'(stall_cnt), 64'd35);

      // Data memory not ready for 300 cycles: freeze and watchdog.
      for (int c = 0; c < 300; c++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clk);
         if (c == 100) begin
            check("mem_freeze", 64'(ctrl), 64'(9'b1111_0001_0));
            check("mem_to_early", 64'(mem_timeout), 64'h0);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      check("mem_release", 64'(ctrl), 64'h0);
      check("mem_to_set", 64'(mem_timeout), 64'h1);
      repeat (3) idle();
      @(negedge clk);
      check("mem_to_sticky", 64'(mem_timeout), 64'h1);
      check("stall_cnt_sat", 64'(stall_cnt), 64'(CMAX));

      // Reset in the middle of a MEM wait.
      for (int c = 0; c < 10; c++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_ctrl", 64'(ctrl), 64'h0);
      check("rst_mid_cnt", 64'({stall_cnt, flush_cnt}), 64'h0);
      check("rst_mid_to", 64'(mem_timeout), 64'h0);
      #2;
      rst_n = 1'b1;
      drive(1, 9, 9, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("post_rst_run", 64'(ctrl), 64'(9'b1100_0100_0));

      // Randomized traffic; legal combinations only (no MEM request while a
      // mul/div waits, no md_done outside a mul/div wait).
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            @(posedge clk);
            #2;
            ex_is_load   = ($urandom_range(0, 1) == 1);
            rd_addr_ex   = 5'($urandom_range(0, 7));
            rs1_addr_id  = 5'($urandom_range(0, 7));
            rs2_addr_id  = 5'($urandom_range(0, 7));
            br_taken_ex  = ($urandom_range(0, 6) == 0);
            md_req_ex    = (m_mode == M_MD) ? 1'b1 : ($urandom_range(0, 19) == 0);
            md_done      = (m_mode == M_MD) && ($urandom_range(0, 7) == 0);
            dmem_req_mem = (m_mode == M_MEM) ? 1'b1 :
                           (m_mode == M_MD)  ? 1'b0 : ($urandom_range(0, 2) == 0);
            dmem_ready   = (m_mode == M_MEM) ? ($urandom_range(0, 5) == 0)
                                             : ($urandom_range(0, 2) != 0);
         end
      end

      idle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
